// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: debounced two-switch LED pattern sequencer (OFF/BLINK/SHIFT/COUNT)
module led_seq_ctrl #(
  parameter int N_LED      = 8,
  parameter int TICK_DIV   = 25_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sw_mode_i,
  input  logic             sw_hold_i,
  output logic [N_LED-1:0] led_o,
  output logic [1:0]       mode_o,
  output logic             tick_o
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {OFF, BLINK, SHIFT, COUNT} state_e;
  state_e state_q, state_d;
  logic [1:0] s1_q, s2_q, deb_q, deb_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic mdly_q;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic tick_q, tick_d;
  logic [N_LED-1:0] led_q, led_d;
  logic dir_q, dir_d;
  logic adv, step, twrap;
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CW'(DEB_CYCLES - 1)) deb_d[i] = s2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    adv    = deb_q[0] & ~mdly_q;
    step   = tick_q & ~deb_q[1] & ~adv;
    twrap  = tcnt_q == TW'(TICK_DIV - 1);
    tcnt_d = (adv || twrap) ? '0 : tcnt_q + 1'b1;
    // a mode change restarts the step interval, so a pending wrap must not strobe
    tick_d  = twrap & ~adv;
    state_d = state_q;
    led_d   = led_q;
    dir_d   = dir_q;
    if (adv) begin
      state_d = state_e'(state_q + 2'd1);
      led_d   = (state_d == BLINK) ? '1 : (state_d == SHIFT) ? N_LED'(1) : '0;
      dir_d   = (state_d == SHIFT) ? 1'b0 : dir_q;
    end else if (step) begin
      case (state_q)
        BLINK: led_d = ~led_q;
        SHIFT: begin
          dir_d = dir_q ? ~led_q[0] : led_q[N_LED-1];
          led_d = dir_d ? led_q >> 1 : led_q << 1;
        end
        COUNT: led_d = led_q + 1'b1;
        default: led_d = '0;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q    <= '0;
      s2_q    <= '0;
      deb_q   <= '0;
      cnt_q   <= '{default: '0};
      mdly_q  <= 1'b0;
      tcnt_q  <= '0;
      tick_q  <= 1'b0;
      state_q <= OFF;
      led_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      s1_q    <= {sw_hold_i, sw_mode_i};
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      mdly_q  <= deb_q[0];
      tcnt_q  <= tcnt_d;
      tick_q  <= tick_d;
      state_q <= state_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
    end
  end
  assign led_o  = led_q;
  assign mode_o = state_q;
  assign tick_o = tick_q;
endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed checks of debounce, mode advance, patterns, hold and reset
module tb_led_seq_ctrl;
  logic clk = 1'b0, rst = 1'b1, sw_mode = 1'b0, sw_hold = 1'b0;
  logic [3:0] led;
  logic [1:0] mode;
  logic tick;
  int pass_n = 0, fail_n = 0, total_n = 0;
  logic [3:0] shift_exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
  led_seq_ctrl #(.N_LED(4), .TICK_DIV(4), .DEB_CYCLES(3)) dut (
    .clk_i(clk), .rst_i(rst), .sw_mode_i(sw_mode), .sw_hold_i(sw_hold),
    .led_o(led), .mode_o(mode), .tick_o(tick)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  initial begin
    cyc(2);
    chk("rst_led", led, 4'b0000);
    chk("rst_mode", {2'b00, mode}, 4'd0);
    chk("rst_tick", {3'b000, tick}, 4'd0);
    rst = 1'b0;
    cyc(3);
    chk("idle_led", led, 4'b0000);
    chk("idle_mode", {2'b00, mode}, 4'd0);
    sw_mode = 1'b1;
    cyc(5);
    chk("adv_early_mode", {2'b00, mode}, 4'd0);
    cyc(1);
    chk("blink_mode", {2'b00, mode}, 4'd1);
    chk("blink_entry", led, 4'b1111);
    cyc(3);
    chk("blink_pre_tick", {3'b000, tick}, 4'd0);
    cyc(1);
    chk("blink_tick", {3'b000, tick}, 4'd1);
    chk("blink_hold_val", led, 4'b1111);
    sw_mode = 1'b0;
    cyc(1);
    chk("blink_t1", led, 4'b0000);
    cyc(3);
    chk("blink_tick2", {3'b000, tick}, 4'd1);
    cyc(1);
    chk("blink_t2", led, 4'b1111);
    sw_mode = 1'b1;
    cyc(2);
    sw_mode = 1'b0;
    cyc(6);
    chk("glitch_mode", {2'b00, mode}, 4'd1);
    chk("glitch_led", led, 4'b1111);
    sw_mode = 1'b1;
    cyc(5);
    chk("shift_early_mode", {2'b00, mode}, 4'd1);
    cyc(1);
    chk("shift_mode", {2'b00, mode}, 4'd2);
    sw_mode = 1'b0;
    chk("shift_entry", led, shift_exp[0]);
    cyc(4);
    chk("shift_wait", led, shift_exp[0]);
    for (int k = 1; k < 8; k++) begin
      cyc(k == 1 ? 1 : 4);
      chk($sformatf("shift_%0d", k), led, shift_exp[k]);
    end
    chk("shift_mode_kept", {2'b00, mode}, 4'd2);
    sw_mode = 1'b1;
    cyc(6);
    chk("count_mode", {2'b00, mode}, 4'd3);
    chk("count_entry", led, 4'b0000);
    sw_mode = 1'b0;
    cyc(5);
    chk("count_1", led, 4'd1);
    for (int k = 2; k <= 16; k++) begin
      cyc(4);
      chk($sformatf("count_%0d", k), led, 4'(k));
    end
    sw_hold = 1'b1;
    cyc(8);
    chk("hold_frozen", led, 4'd1);
    cyc(3);
    chk("hold_tick", {3'b000, tick}, 4'd1);
    chk("hold_frozen2", led, 4'd1);
    cyc(4);
    chk("hold_tick2", {3'b000, tick}, 4'd1);
    sw_hold = 1'b0;
    cyc(8);
    chk("release_pre", led, 4'd1);
    cyc(1);
    chk("release_resume", led, 4'd2);
    cyc(12);
    chk("count_0101", led, 4'b0101);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mid_rst_led", led, 4'b0000);
    chk("mid_rst_mode", {2'b00, mode}, 4'd0);
    chk("mid_rst_tick", {3'b000, tick}, 4'd0);
    cyc(3);
    chk("post_rst_notick", {3'b000, tick}, 4'd0);
    cyc(1);
    chk("post_rst_tick", {3'b000, tick}, 4'd1);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
